// File: rtl/jtcop_bus_pkg.sv
// Shared CPU bus definitions for the jtcop DTACK and clock-enable logic.
// FSM encoding, default divider ratio and a width helper.
package jtcop_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dtack_st_t;

  localparam int CEN_NUM_DEF = 5;
  localparam int CEN_DEN_DEF = 24;
  localparam int MAXREC_DEF  = 15;

  function automatic int bits_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtcop_dtack_if.sv
// 68000 bus strobes, memory status and the enables/DTACK returned to the CPU.
// The CPU side drives strobes and memory status; the DTACK block answers.
interface jtcop_dtack_if;
  logic       ASn;
  logic [1:0] DSn;
  logic       bus_cs;
  logic       bus_busy;
  logic       cpu_cen;
  logic       cpu_cenb;
  logic       DTACKn;

  modport master (
    output ASn, DSn, bus_cs, bus_busy,
    input  cpu_cen, cpu_cenb, DTACKn
  );

  modport slave (
    input  ASn, DSn, bus_cs, bus_busy,
    output cpu_cen, cpu_cenb, DTACKn
  );
endinterface

// File: rtl/jtcop_frac_cen.sv
// Fractional CPU clock-enable generator with missed-pulse recovery.
// Suppressed cpu_cen pulses are counted and re-injected in idle clocks.
module jtcop_frac_cen
  import jtcop_bus_pkg::*;
#(
  parameter int CEN_NUM = CEN_NUM_DEF,
  parameter int CEN_DEN = CEN_DEN_DEF,
  parameter int MAXREC  = MAXREC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  output logic cpu_cen,
  output logic cpu_cenb
);

  localparam int AW = bits_for(CEN_NUM + CEN_DEN - 1);
  localparam int MW = bits_for(MAXREC);
  localparam logic [AW-1:0] NUM  = AW'(CEN_NUM);
  localparam logic [AW-1:0] DEN  = AW'(CEN_DEN);
  localparam logic [MW-1:0] MAXM = MW'(MAXREC);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_n;
  logic [MW-1:0] miss;
  logic          prev;
  logic          ph_b;
  logic          ap;
  logic          rec;
  logic          fire;

  always_comb begin
    acc_n = acc + NUM;
    ap    = acc_n >= DEN;
    rec   = ~halt & (miss != '0) & ~ap & ~prev;
    fire  = ap | rec;
  end

  // ph_b toggles on suppressed pulses too, so cen/cenb order never breaks
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      miss     <= '0;
      prev     <= 1'b0;
      ph_b     <= 1'b0;
      cpu_cen  <= 1'b0;
      cpu_cenb <= 1'b0;
    end else begin
      acc      <= ap ? acc_n - DEN : acc_n;
      prev     <= ap;
      ph_b     <= ph_b ^ fire;
      cpu_cen  <= ~ph_b & (rec | (ap & ~halt));
      cpu_cenb <= ph_b & fire;
      if (ap & ~ph_b & halt) begin
        if (miss != MAXM) miss <= miss + 1'b1;
      end else if (rec) begin
        miss <= miss - 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcop_dtack.sv
// 68000 DTACK generator: halts cpu_cen while SDRAM data is pending.
// Acknowledge drops in the same clk the address strobe is released.
module jtcop_dtack
  import jtcop_bus_pkg::*;
#(
  parameter int CEN_NUM = CEN_NUM_DEF,
  parameter int CEN_DEN = CEN_DEN_DEF,
  parameter int MAXREC  = MAXREC_DEF,
  parameter bit WAIT1   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  jtcop_dtack_if.slave  bus
);

  dtack_st_t st;
  logic      wcnt;
  logic      halt;
  logic      ds_act;
  logic      fast_ok;

  assign bus.DTACKn = ~(st == ST_ACK) | bus.ASn;
  assign halt    = ~bus.ASn & bus.bus_cs & bus.bus_busy & bus.DTACKn;
  assign ds_act  = bus.DSn != 2'b11;
  assign fast_ok = (WAIT1 == 1'b0) | wcnt;

  jtcop_frac_cen #(
    .CEN_NUM (CEN_NUM),
    .CEN_DEN (CEN_DEN),
    .MAXREC  (MAXREC)
  ) u_cen (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .cpu_cen  (bus.cpu_cen),
    .cpu_cenb (bus.cpu_cenb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= ST_IDLE;
      wcnt <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE:
          if (bus.cpu_cenb & ~bus.ASn & ds_act) begin
            st   <= ST_WAIT;
            wcnt <= 1'b0;
          end
        ST_WAIT:
          if (bus.ASn) begin
            st <= ST_IDLE;
          end else if (bus.cpu_cenb) begin
            if (bus.bus_cs ? ~bus.bus_busy : fast_ok) st <= ST_ACK;
            else if (~bus.bus_cs) wcnt <= 1'b1;
          end
        ST_ACK:
          if (bus.ASn) st <= ST_IDLE;
        default:
          st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_dtack.sv
// Bench for jtcop_dtack: two instances (WAIT1=0/1) against a cycle model.
// Directed bus scenarios followed by a randomized bus phase.
module tb_jtcop_dtack;
  import jtcop_bus_pkg::*;

  localparam int NUM  = 5;
  localparam int DEN  = 24;
  localparam int MAXR = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n = 1'b1;
  logic [1:0] ds = 2'b11;
  logic       cs = 1'b0;
  logic       busy = 1'b0;

  int checks = 0;
  int failures = 0;

  jtcop_dtack_if b0 ();
  jtcop_dtack_if b1 ();

  assign b0.ASn = as_n;
  assign b0.DSn = ds;
  assign b0.bus_cs = cs;
  assign b0.bus_busy = busy;
  assign b1.ASn = as_n;
  assign b1.DSn = ds;
  assign b1.bus_cs = cs;
  assign b1.bus_busy = busy;

  jtcop_dtack #(
    .CEN_NUM(NUM), .CEN_DEN(DEN), .MAXREC(MAXR), .WAIT1(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  jtcop_dtack #(
    .CEN_NUM(NUM), .CEN_DEN(DEN), .MAXREC(MAXR), .WAIT1(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  always #5 clk = ~clk;

  // reference model state, one slot per instance (index == WAIT1)
  int m_acc[2];
  int m_miss[2];
  int m_left[2];
  bit m_nextb[2];
  bit m_prev[2];
  bit m_cen[2];
  bit m_cenb[2];
  bit m_req[2];
  bit m_ack[2];

  function automatic bit m_dtn(input int i);
    return !(m_ack[i] && !as_n);
  endfunction

  task automatic mstep(input int i);
    bit halt;
    bit ap;
    bit rec;
    if (rst) begin
      m_acc[i] = 0; m_miss[i] = 0; m_left[i] = 0;
      m_nextb[i] = 0; m_prev[i] = 0; m_cen[i] = 0;
      m_cenb[i] = 0; m_req[i] = 0; m_ack[i] = 0;
      return;
    end
    halt = !as_n && cs && busy && m_dtn(i);
    if (as_n) begin
      m_req[i] = 0;
      m_ack[i] = 0;
    end else if (m_cenb[i]) begin
      if (m_req[i]) begin
        if (cs) begin
          if (!busy) begin m_req[i] = 0; m_ack[i] = 1; end
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_req[i] = 0; m_ack[i] = 1; end
        end
      end else if (!m_ack[i] && ds != 2'b11) begin
        m_req[i] = 1;
        m_left[i] = i + 1;
      end
    end
    m_acc[i] += NUM;
    ap = m_acc[i] >= DEN;
    if (ap) m_acc[i] -= DEN;
    rec = !halt && m_miss[i] > 0 && !ap && !m_prev[i];
    m_cen[i] = 0;
    m_cenb[i] = 0;
    if (ap || rec) begin
      if (m_nextb[i]) m_cenb[i] = 1;
      else if (ap && halt) m_miss[i] = (m_miss[i] < MAXR) ? m_miss[i] + 1 : MAXR;
      else m_cen[i] = 1;
      if (rec) m_miss[i]--;
      m_nextb[i] = !m_nextb[i];
    end
    m_prev[i] = ap;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk("cen0", b0.cpu_cen, m_cen[0]);
    chk("cenb0", b0.cpu_cenb, m_cenb[0]);
    chk("dtackn0", b0.DTACKn, m_dtn(0));
    chk("cen1", b1.cpu_cen, m_cen[1]);
    chk("cenb1", b1.cpu_cenb, m_cenb[1]);
    chk("dtackn1", b1.DTACKn, m_dtn(1));
  endtask

  initial begin
    int n_cen, n_cenb, n, alt_bad, cb, cnt0, cnt1, lowseen, first;
    bit last_b, acked, d0, d1;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cen", b0.cpu_cen, 0);
    chk("rst_cenb", b0.cpu_cenb, 0);
    chk("rst_dtackn", b0.DTACKn, 1);
    chk("rst_miss", dut0.u_cen.miss, 0);
    rst = 1'b0;

    n_cen = 0; n_cenb = 0; alt_bad = 0; last_b = 1;
    repeat (2400) begin
      tick();
      if (b0.cpu_cen) begin
        n_cen++;
        if (!last_b) alt_bad++;
        last_b = 0;
      end
      if (b0.cpu_cenb) begin
        n_cenb++;
        if (last_b) alt_bad++;
        last_b = 1;
      end
      if (dut0.u_cen.miss != 0) alt_bad++;
    end
    chk("free_cen", n_cen, 250);
    chk("free_cenb", n_cenb, 250);
    chk("free_alt_miss", alt_bad, 0);

    as_n = 0; ds = 2'b00; cs = 1; busy = 1;
    repeat (40) tick();
    chk("halt_miss0", dut0.u_cen.miss, 4);
    chk("halt_miss1", dut1.u_cen.miss, 4);
    chk("halt_dtackn", b0.DTACKn, 1);
    busy = 0; n = 0; cb = int'(b0.cpu_cenb); acked = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      n += int'(b0.cpu_cen) + int'(b0.cpu_cenb);
      if (!acked) begin
        if (!b0.DTACKn) acked = 1;
        else cb += int'(b0.cpu_cenb);
      end
    end
    chk("recover_pulses", n, 9);
    chk("recover_miss", dut0.u_cen.miss, 0);
    chk("ack_first_cenb", cb, 1);
    chk("ack_held", b0.DTACKn, 0);
    as_n = 1;
    #1;
    chk("ack_release0", b0.DTACKn, 1);
    chk("ack_release1", b1.DTACKn, 1);
    ds = 2'b11; cs = 0;
    repeat (10) tick();

    as_n = 0; ds = 2'b10; cs = 1; busy = 1;
    repeat (400) tick();
    chk("sat_miss0", dut0.u_cen.miss, 15);
    chk("sat_miss1", dut1.u_cen.miss, 15);
    busy = 0; n = 0;
    repeat (240) begin
      tick();
      n += int'(b0.cpu_cen) + int'(b0.cpu_cenb);
    end
    chk("sat_pulses", n, 65);
    chk("sat_miss_after", dut0.u_cen.miss, 0);
    as_n = 1; ds = 2'b11; cs = 0;
    repeat (10) tick();

    as_n = 0; ds = 2'b01; cs = 0;
    cnt0 = int'(b0.cpu_cenb); cnt1 = int'(b1.cpu_cenb); d0 = 0; d1 = 0;
    for (int k = 0; k < 200 && !(d0 && d1); k++) begin
      tick();
      if (!d0) begin
        if (!b0.DTACKn) d0 = 1;
        else cnt0 += int'(b0.cpu_cenb);
      end
      if (!d1) begin
        if (!b1.DTACKn) d1 = 1;
        else cnt1 += int'(b1.cpu_cenb);
      end
    end
    chk("fast_done0", d0, 1);
    chk("fast_done1", d1, 1);
    chk("fast_cenb0", cnt0, 2);
    chk("fast_cenb1", cnt1, 3);
    as_n = 1;
    #1;
    chk("fast_rel0", b0.DTACKn, 1);
    chk("fast_rel1", b1.DTACKn, 1);
    ds = 2'b11;
    repeat (10) tick();

    as_n = 0; ds = 2'b00; cs = 1; busy = 1; lowseen = 0;
    repeat (30) begin
      tick();
      if (!b0.DTACKn || !b1.DTACKn) lowseen++;
    end
    chk("abort_wait_state", dut0.st, ST_WAIT);
    as_n = 1; busy = 0;
    repeat (20) begin
      tick();
      if (!b0.DTACKn || !b1.DTACKn) lowseen++;
    end
    chk("abort_no_ack", lowseen, 0);
    chk("abort_idle0", dut0.st, ST_IDLE);
    chk("abort_idle1", dut1.st, ST_IDLE);

    as_n = 0; cs = 1; busy = 1; lowseen = 0;
    repeat (30) begin
      tick();
      if (!b0.DTACKn || !b1.DTACKn) lowseen++;
    end
    rst = 1;
    tick();
    chk("rstw_no_ack", lowseen, 0);
    chk("rstw_dtackn", b0.DTACKn, 1);
    chk("rstw_cen", b0.cpu_cen, 0);
    chk("rstw_cenb", b0.cpu_cenb, 0);
    chk("rstw_miss", dut0.u_cen.miss, 0);
    chk("rstw_idle", dut1.st, ST_IDLE);
    rst = 0; as_n = 1; cs = 0; busy = 0; ds = 2'b11;
    first = 0;
    for (int k = 0; k < 60 && first == 0; k++) begin
      tick();
      if (b0.cpu_cen) first = 1;
      else if (b0.cpu_cenb) first = 2;
    end
    chk("rstw_first_cen", first, 1);

    repeat (3000) begin
      if ($urandom_range(15) == 0) begin
        as_n = !as_n;
        if (!as_n) begin
          ds = 2'($urandom_range(3));
          cs = 1'($urandom_range(1));
        end
      end
      if ($urandom_range(7) == 0) busy = !busy;
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtcop_dtack.md
JTCOP_DTACK -- requirements
Module: jtcop_dtack

Interface
REQ-001 SHALL have parameter CEN_NUM, default 5, meaning the fractional clock-enable numerator.
REQ-002 SHALL have parameter CEN_DEN, default 24, meaning the denominator; the defaults give 48 MHz -> 10 MHz CPU pulses.
REQ-003 SHALL have parameter MAXREC, default 15, meaning the saturation limit of the missed-cen counter.
REQ-004 SHALL have parameter WAIT1, default 0, meaning one extra cpu_cenb wait state on fast (non-SDRAM) accesses when 1.
REQ-005 SHALL have ports clk in 1 (system clock, single domain) and rst in 1 (synchronous, active-high reset).
REQ-006 SHALL have port ASn in 1: 68000 address strobe, active low.
REQ-007 SHALL have port DSn in 2: {UDSn,LDSn}, active low.
REQ-008 SHALL have port bus_cs in 1: current access targets SDRAM-backed memory (ROM/RAM/VRAM).
REQ-009 SHALL have port bus_busy in 1: SDRAM data not yet valid (bus_cs & ~ram_ok).
REQ-010 SHALL have port cpu_cen out 1: CPU rising-phase enable, one clk wide.
REQ-011 SHALL have port cpu_cenb out 1: CPU falling-phase enable, one clk wide.
REQ-012 SHALL have port DTACKn out 1: data acknowledge to the CPU, active low.

Function
REQ-013 Accumulator, one step per clk: acc_n = acc + CEN_NUM; if acc_n >= CEN_DEN, it SHALL set acc = acc_n - CEN_DEN and raise a phase pulse.
REQ-014 Phase pulses SHALL alternate cpu_cen, cpu_cenb, ..., starting with cpu_cen after reset; the two outputs are never high in the same clk.
REQ-015 Halt: while ASn=0, bus_cs=1, bus_busy=1 and DTACKn=1, every cpu_cen pulse SHALL be suppressed.
REQ-016 Each suppressed pulse SHALL increment miss, saturating at MAXREC; cpu_cenb pulses are never suppressed and the phase order is kept.
REQ-017 Recovery: when not halted, miss>0, there is no accumulator pulse this clk and none in the previous clk, the block SHALL emit the next-phase pulse and decrement miss.
REQ-018 At most one pulse SHALL be emitted per clk; an accumulator pulse always takes priority over recovery.
REQ-019 DTACK FSM states: IDLE, WAIT, ACK.
REQ-020 IDLE->WAIT SHALL occur on the cpu_cenb where ASn=0 and DSn!=2'b11.
REQ-021 WAIT->ACK SHALL occur on the first cpu_cenb where (bus_cs=0, plus one extra cpu_cenb if WAIT1) or (bus_cs=1 and bus_busy=0).
REQ-022 DTACKn SHALL be low exactly in ACK.
REQ-023 ACK->IDLE SHALL occur in the first clk where ASn=1, with DTACKn=1 in that same clk.
REQ-024 ASn rising while in WAIT SHALL return the FSM to IDLE with DTACKn held high and no acknowledge issued.
REQ-025 bus_busy falling and ASn rising in the same clk: ASn takes priority, and the FSM goes to IDLE.
REQ-026 The accumulator SHALL be wide enough for CEN_NUM+CEN_DEN-1 without overflow; acc always stays below CEN_DEN.

Reset
REQ-027 On rst, the block SHALL set acc=0, miss=0, FSM=IDLE, DTACKn=1, cpu_cen=0, cpu_cenb=0, and the next phase to cpu_cen.
REQ-028 rst asserted mid-access SHALL abort the access with no acknowledge; outputs follow REQ-027 in the next clk.

Structure
REQ-029 FSM state encoding and the default CEN_NUM/CEN_DEN constants SHALL live in the shared package jtcop_bus_pkg.
REQ-030 The fractional divider (accumulator, phase toggle, recovery injection) SHALL be the sub-module jtcop_frac_cen.
REQ-031 jtcop_dtack SHALL instantiate jtcop_frac_cen and hold the FSM and halt logic itself.

Verification
REQ-032 Free-run with ASn=1 for 2400 clk -> exactly 250 cpu_cen and 250 cpu_cenb pulses, strictly alternating, and miss stays 0.
REQ-033 bus_cs=1 read with bus_busy=1 for 40 clk -> 4 cpu_cen suppressed, miss=4, DTACKn low on the first cpu_cenb after bus_busy falls; the next 24 clk produce 9 pulses instead of 5 (recovery), then miss=0.
REQ-034 bus_busy held for 400 clk -> miss saturates at 15 and does not wrap; after release, exactly 15 extra pulses are emitted.
REQ-035 Fast access (bus_cs=0), WAIT1=0 then WAIT1=1 -> DTACKn low 1 cpu_cenb, respectively 2 cpu_cenb, after the ASn-sampling cpu_cenb; high in the same clk ASn rises.
REQ-036 ASn raised during WAIT, and separately rst pulsed during WAIT -> DTACKn never goes low, FSM=IDLE, and after rst the first pulse is cpu_cen with miss=0.
